// File: rtl/bist_scan_sequencer_pkg.sv
// Shared types for the BIST scan sequencer: state encoding, control bundle and
// the per-state Moore control decode.
package bist_scan_sequencer_pkg;

    localparam int DEF_SCAN_LEN   = 12;
    localparam int DEF_N_PATTERNS = 1024;
    localparam int DEF_SIG_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    typedef struct packed {
        logic bist_mode;
        logic scan_en;
        logic lfsr_init;
        logic lfsr_en;
        logic misr_init;
        logic misr_en;
    } ctrl_t;

    // Counter width that stays at least 1 bit for degenerate parameter values.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_INIT: begin
                c.bist_mode = 1'b1;
                c.lfsr_init = 1'b1;
                c.misr_init = 1'b1;
            end
            ST_SHIFT: begin
                c.bist_mode = 1'b1;
                c.scan_en   = 1'b1;
                c.lfsr_en   = 1'b1;
                c.misr_en   = 1'b1;
            end
            ST_FLUSH: begin
                c.bist_mode = 1'b1;
                c.scan_en   = 1'b1;
                c.misr_en   = 1'b1;
            end
            ST_CAPTURE, ST_COMPARE: c.bist_mode = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bist_scan_sequencer_edge_detect.sv
// Rising-edge detector for bist_start; the history flop resets to 1 so a start
// already high at reset release is not mistaken for a new request.
module bist_scan_sequencer_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic bist_start,
    output logic go
);

    logic start_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b1;
        end else begin
            start_q <= bist_start;
        end
    end

    assign go = bist_start & ~start_q;

endmodule

// File: rtl/bist_scan_sequencer.sv
// BIST run sequencer: init, N_PATTERNS x (shift, capture), flush, signature
// compare, with all controls registered as Moore outputs of the next state.
module bist_scan_sequencer
    import bist_scan_sequencer_pkg::*;
#(
    parameter int             SCAN_LEN   = DEF_SCAN_LEN,
    parameter int             N_PATTERNS = DEF_N_PATTERNS,
    parameter int             SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             bist_mode,
    output logic             scan_en,
    output logic             lfsr_init,
    output logic             lfsr_en,
    output logic             misr_init,
    output logic             misr_en,
    output logic             bist_end,
    output logic             pass_nfail
);

    localparam int BIT_W = cnt_w(SCAN_LEN);
    localparam int PAT_W = cnt_w(N_PATTERNS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(N_PATTERNS - 1);

    state_t           state;
    ctrl_t            ctrl_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [PAT_W-1:0] pat_cnt;
    logic             go;

    bist_scan_sequencer_edge_detect u_edge (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
        .go         (go)
    );

    // Every transition loads the control word of the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ctrl_q     <= '0;
            bit_cnt    <= '0;
            pat_cnt    <= '0;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state      <= ST_INIT;
                        ctrl_q     <= ctrl_for(ST_INIT);
                        bist_end   <= 1'b0;
                        pass_nfail <= 1'b0;
                    end
                end
                ST_INIT: begin
                    bit_cnt <= '0;
                    pat_cnt <= '0;
                    state   <= ST_SHIFT;
                    ctrl_q  <= ctrl_for(ST_SHIFT);
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= ST_CAPTURE;
                        ctrl_q  <= ctrl_for(ST_CAPTURE);
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (pat_cnt == LAST_PAT) begin
                        state  <= ST_FLUSH;
                        ctrl_q <= ctrl_for(ST_FLUSH);
                    end else begin
                        pat_cnt <= pat_cnt + PAT_W'(1);
                        state   <= ST_SHIFT;
                        ctrl_q  <= ctrl_for(ST_SHIFT);
                    end
                end
                ST_FLUSH: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= ST_COMPARE;
                        ctrl_q  <= ctrl_for(ST_COMPARE);
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    pass_nfail <= (misr_sig == GOLDEN_SIG);
                    bist_end   <= 1'b1;
                    state      <= ST_DONE;
                    ctrl_q     <= ctrl_for(ST_DONE);
                end
                default: begin
                    state  <= ST_IDLE;
                    ctrl_q <= '0;
                end
            endcase
        end
    end

    assign bist_mode = ctrl_q.bist_mode;
    assign scan_en   = ctrl_q.scan_en;
    assign lfsr_init = ctrl_q.lfsr_init;
    assign lfsr_en   = ctrl_q.lfsr_en;
    assign misr_init = ctrl_q.misr_init;
    assign misr_en   = ctrl_q.misr_en;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Scoreboard bench for bist_scan_sequencer: runs are queued at start, and a
// monitor checks latency, verdict and per-run control cycle counts at bist_end.
module tb_bist_scan_sequencer;

    localparam int          L    = 12;
    localparam int          N    = 16;
    localparam int          SW   = 16;
    localparam logic [15:0] GOLD = 16'hA5C3;
    localparam int          LAT  = 1 + N * (L + 1) + L + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          bist_start;
    logic [SW-1:0] misr_sig;
    logic bist_mode, scan_en, lfsr_init, lfsr_en, misr_init, misr_en, bist_end, pass_nfail;

    bist_scan_sequencer #(
        .SCAN_LEN   (L),
        .N_PATTERNS (N),
        .SIG_W      (SW),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
        .misr_sig   (misr_sig),
        .bist_mode  (bist_mode),
        .scan_en    (scan_en),
        .lfsr_init  (lfsr_init),
        .lfsr_en    (lfsr_en),
        .misr_init  (misr_init),
        .misr_en    (misr_en),
        .bist_end   (bist_end),
        .pass_nfail (pass_nfail)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int go_cyc;
        bit pass;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Signature stimulus: never golden except on the single compare edge.
    int          cmp_edge = 0;
    logic [15:0] cmp_val  = '0;
    initial begin
        misr_sig = '0;
        forever begin
            @(negedge clock);
            if (cyc + 1 == cmp_edge) misr_sig = cmp_val;
            else misr_sig = GOLD ^ 16'($urandom_range(1, 65535));
        end
    end

    // Monitor: accumulate per-run control activity, score at each bist_end rise.
    initial begin
        int a_shift, a_flush, a_cap, a_linit, a_minit, a_men, hi_run;
        logic end_d;
        exp_t e;
        a_shift = 0; a_flush = 0; a_cap = 0; a_linit = 0; a_minit = 0; a_men = 0;
        hi_run = 0; end_d = 1'b0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                a_shift = 0; a_flush = 0; a_cap = 0; a_linit = 0; a_minit = 0; a_men = 0;
                hi_run = 0; end_d = 1'b0;
            end else begin
                if (scan_en && lfsr_en) a_shift++;
                if (scan_en && !lfsr_en) a_flush++;
                if (bist_mode && !scan_en) a_cap++;
                if (lfsr_init) a_linit++;
                if (misr_init) a_minit++;
                if (misr_en) a_men++;
                if (scan_en) hi_run++;
                else if (hi_run != 0) begin
                    check("scan_burst_len", hi_run, L);
                    hi_run = 0;
                end
                if (bist_end && !end_d) begin
                    if (sb.size() == 0) begin
                        check("unexpected_bist_end", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", cyc - e.go_cyc, LAT);
                        check("pass_nfail", int'(pass_nfail), int'(e.pass));
                        check("shift_cycles", a_shift, N * L);
                        check("flush_cycles", a_flush, L);
                        check("scan_low_cycles", a_cap, N + 2);
                        check("lfsr_init_pulses", a_linit, 1);
                        check("misr_init_pulses", a_minit, 1);
                        check("misr_en_cycles", a_men, N * L + L);
                    end
                    a_shift = 0; a_flush = 0; a_cap = 0; a_linit = 0; a_minit = 0; a_men = 0;
                end
                end_d = bist_end;
            end
        end
    end

    function automatic int outs();
        return int'({bist_mode, scan_en, lfsr_init, lfsr_en, misr_init, misr_en,
                     bist_end, pass_nfail});
    endfunction

    // Caller guarantees bist_start was low on the previous edge.
    task automatic do_go(input bit good);
        exp_t        e;
        logic [15:0] flip;
        @(negedge clock);
        e.go_cyc = cyc + 1;
        e.pass   = good;
        sb.push_back(e);
        flip     = 16'h1 << $urandom_range(0, 15);
        cmp_val  = good ? GOLD : (GOLD ^ flip);
        cmp_edge = e.go_cyc + LAT;
        bist_start = 1'b1;
    endtask

    task automatic wait_end(input string name);
        int k;
        k = 0;
        repeat (2) @(negedge clock);
        while (bist_end !== 1'b1 && k < LAT + 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= LAT + 50) check(name, 0, 1);
    endtask

    task automatic abort_run();
        void'(sb.pop_back());
        cmp_edge = 0;
    endtask

    initial begin
        reset = 1'b0;
        bist_start = 1'b0;
        repeat (20) @(negedge clock);
        check("reset_outputs", outs(), 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_after_reset", outs(), 0);

        // Basic fault-free run, start held for a while.
        do_go(1'b1);
        repeat (10) @(negedge clock);
        bist_start = 1'b0;
        wait_end("timeout_run1");

        // Re-pulse mid-run must be ignored.
        do_go($urandom_range(0, 1) == 1);
        repeat ($urandom_range(1, 40)) @(negedge clock);
        bist_start = 1'b0;
        repeat (100 - 40) @(negedge clock);
        bist_start = 1'b1;
        @(negedge clock);
        bist_start = 1'b0;
        wait_end("timeout_repulse");

        // Stuck-at bit at compare.
        repeat (5) @(negedge clock);
        do_go(1'b0);
        @(negedge clock);
        bist_start = 1'b0;
        wait_end("timeout_fault");

        // Randomized back-to-back runs, restarting from DONE.
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 8)) @(negedge clock);
            do_go($urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 30)) @(negedge clock);
            bist_start = 1'b0;
            wait_end("timeout_random");
        end

        // Mid-run reset with start held high.
        do_go(1'b1);
        repeat ($urandom_range(20, 150)) @(negedge clock);
        reset = 1'b0;
        abort_run();
        @(negedge clock);
        check("midrun_reset_outputs", outs(), 0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("idle_start_held", outs(), 0);

        // Fresh 0->1 after the abort gives a full run.
        bist_start = 1'b0;
        do_go(1'b1);
        @(negedge clock);
        bist_start = 1'b0;
        wait_end("timeout_after_abort");

        // Start rising while in reset, released with start high.
        reset = 1'b0;
        @(negedge clock);
        check("reset_clears_done", outs(), 0);
        repeat (3) @(negedge clock);
        bist_start = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("idle_start_in_reset", outs(), 0);

        // Start rising in the same cycle as reset release.
        reset = 1'b0;
        bist_start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bist_start = 1'b1;
        repeat (30) @(negedge clock);
        check("idle_start_at_release", outs(), 0);

        bist_start = 1'b0;
        do_go(1'b1);
        repeat (3) @(negedge clock);
        bist_start = 1'b0;
        wait_end("timeout_final");
        repeat (5) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
